// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle CPU control FSM with memory-wait timeout and trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int OP_W        = 6,
    parameter int ALU_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [OP_W-1:0]  op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_dest,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_byte,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             branch_taken,
    output logic             jump,
    output logic             tlb_write,
    output logic             iret,
    output logic             illegal_op,
    output logic             busy,
    output logic [ALU_W-1:0] alu_ctrl
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [OP_W-1:0] OP_OR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LDB  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LDW  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_STB  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_STW  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_MOV  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_JUMP = OP_W'(21);
    localparam logic [OP_W-1:0] OP_TLBW = OP_W'(30);
    localparam logic [OP_W-1:0] OP_IRET = OP_W'(31);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t           state_q;
    logic [OP_W-1:0]  op_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_nxt;

    logic is_alu_rr, is_addi, is_load, is_store, is_byte;
    logic is_beq, is_jump, is_tlbw, is_iret, is_legal;

    assign is_alu_rr = (op_q <= OP_OR);
    assign is_addi   = (op_q == OP_ADDI);
    assign is_load   = (op_q == OP_LDB) || (op_q == OP_LDW);
    assign is_store  = (op_q == OP_STB) || (op_q == OP_STW) || (op_q == OP_MOV);
    assign is_byte   = (op_q == OP_LDB) || (op_q == OP_STB);
    assign is_beq    = (op_q == OP_BEQ);
    assign is_jump   = (op_q == OP_JUMP);
    assign is_tlbw   = (op_q == OP_TLBW);
    assign is_iret   = (op_q == OP_IRET);
    assign is_legal  = is_alu_rr || is_addi || is_load || is_store ||
                       is_beq || is_jump || is_tlbw || is_iret;

    assign wait_nxt = wait_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            op_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (instr_valid) begin
                        op_q    <= op;
                        state_q <= DECODE;
                    end
                end
                DECODE: state_q <= is_legal ? EXEC : TRAP;
                EXEC: begin
                    wait_cnt_q <= '0;
                    if (is_alu_rr || is_addi)      state_q <= WB;
                    else if (is_load || is_store)  state_q <= MEM;
                    else                           state_q <= FETCH;
                end
                MEM: begin
                    // A ready on the final allowed wait cycle still completes the access.
                    if (mem_ready) begin
                        state_q <= is_load ? WB : FETCH;
                    end else begin
                        wait_cnt_q <= wait_nxt;
                        if (wait_nxt == CNT_W'(MEM_TIMEOUT)) state_q <= TRAP;
                    end
                end
                WB:      state_q <= FETCH;
                TRAP:    state_q <= TRAP;
                default: state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_dest     = 1'b0;
        alu_src      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_byte     = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        tlb_write    = 1'b0;
        iret         = 1'b0;
        illegal_op   = 1'b0;
        alu_ctrl     = '0;
        busy         = (state_q != FETCH);
        case (state_q)
            FETCH: begin
                ir_write = instr_valid;
                pc_write = instr_valid;
            end
            EXEC: begin
                if (is_alu_rr) begin
                    reg_dest = 1'b1;
                    alu_ctrl = ALU_W'(op_q);
                end
                if (is_addi || is_load || is_store) alu_src = 1'b1;
                if (is_beq) begin
                    alu_ctrl     = ALU_W'(1);
                    branch_taken = zero;
                    pc_write     = zero;
                end
                if (is_jump) begin
                    jump     = 1'b1;
                    pc_write = 1'b1;
                end
                if (is_tlbw) tlb_write = 1'b1;
                if (is_iret) begin
                    iret     = 1'b1;
                    pc_write = 1'b1;
                end
            end
            MEM: begin
                mem_read  = is_load;
                mem_write = is_store;
                mem_byte  = is_byte;
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                reg_dest   = is_alu_rr;
            end
            TRAP:    illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire
